// File: rtl/mod12_pkg.sv
// Shared constants, command encodings and FSM state type for the mod-12 counter controller.
package mod12_pkg;

   localparam int unsigned MODULUS_DEF = 12;
   localparam int unsigned CW_DEF      = 4;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_SEEK = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      STEP = 2'b10,
      RESP = 2'b11
   } ctrl_state_t;

endpackage

// File: rtl/mod12_dist.sv
// Shortest-path distance on the modular ring: direction and step count from cur to tgt.
module mod12_dist
   import mod12_pkg::*;
#(
   parameter int unsigned MODULUS = MODULUS_DEF,
   parameter int unsigned CW      = CW_DEF
) (
   input  logic [CW-1:0] cur,
   input  logic [CW-1:0] tgt,
   output logic          dir,
   output logic [CW-1:0] steps,
   output logic          bad
);

   localparam logic [CW:0] Mod  = (CW+1)'(MODULUS);
   localparam logic [CW:0] Half = (CW+1)'(MODULUS / 2);

   logic [CW:0] cur_w;
   logic [CW:0] tgt_w;
   logic [CW:0] d_up;
   logic [CW:0] d_dn;

   always_comb begin
      cur_w = {1'b0, cur};
      tgt_w = {1'b0, tgt};
      bad   = (cur_w >= Mod) || (tgt_w >= Mod);

      if (tgt_w >= cur_w) begin
         d_up = tgt_w - cur_w;
      end else begin
         d_up = tgt_w + Mod - cur_w;
      end
      d_dn = Mod - d_up;

      // A tie at half the ring resolves upward.
      if (bad) begin
         dir   = 1'b0;
         steps = '0;
      end else if (d_up <= Half) begin
         dir   = 1'b1;
         steps = d_up[CW-1:0];
      end else begin
         dir   = 1'b0;
         steps = d_dn[CW-1:0];
      end
   end

endmodule

// File: rtl/mod12_count_ctrl.sv
// Command-driven controller for a free-running mod-12 up/down counter: load, step, seek.
module mod12_count_ctrl
   import mod12_pkg::*;
#(
   parameter int unsigned MODULUS = MODULUS_DEF,
   parameter int unsigned CW      = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [CW-1:0] cmd_arg,
   input  logic [CW-1:0] count,
   output logic          load,
   output logic          mode,
   output logic [CW-1:0] data_in,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [CW-1:0] MaxVal = CW'(MODULUS - 1);

   ctrl_state_t   state_q, state_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [CW-1:0] arg_q, arg_d;
   logic          dir_q, dir_d;
   logic          err_q, err_d;

   logic          accept;
   logic          seek_dir;
   logic [CW-1:0] seek_steps;
   logic          seek_bad;

   mod12_dist #(
      .MODULUS (MODULUS),
      .CW      (CW)
   ) u_dist (
      .cur   (count),
      .tgt   (cmd_arg),
      .dir   (seek_dir),
      .steps (seek_steps),
      .bad   (seek_bad)
   );

   assign accept = cmd_valid && (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      arg_d   = arg_q;
      dir_d   = dir_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               arg_d = cmd_arg;
               rem_d = '0;
               dir_d = 1'b0;
               err_d = 1'b0;
               unique case (cmd_op)
                  OP_LOAD: begin
                     if (cmd_arg > MaxVal) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                     end else begin
                        state_d = LOAD;
                     end
                  end
                  OP_UP, OP_DOWN: begin
                     dir_d   = (cmd_op == OP_UP);
                     rem_d   = cmd_arg;
                     state_d = (cmd_arg == '0) ? RESP : STEP;
                  end
                  OP_SEEK: begin
                     if (seek_bad) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                     end else begin
                        dir_d   = seek_dir;
                        rem_d   = seek_steps;
                        state_d = (seek_steps == '0) ? RESP : STEP;
                     end
                  end
                  default: state_d = IDLE;
               endcase
            end
         end
         LOAD: state_d = RESP;
         STEP: begin
            rem_d = rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
               state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         arg_q   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         arg_q   <= arg_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   // The counter has no enable, so "hold" means reloading its own value every cycle.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      load      = (state_q != STEP);
      mode      = (state_q == STEP) && dir_q;
      data_in   = (state_q == LOAD) ? arg_q : count;
      done      = (state_q == RESP);
      err       = (state_q == RESP) && err_q;
   end

   a_err_with_done : assert property (@(posedge clk) disable iff (!rst) err |-> done);
   a_resp_to_idle  : assert property (@(posedge clk) disable iff (!rst)
                                      (state_q == RESP) |=> (state_q == IDLE));
   a_step_nonzero  : assert property (@(posedge clk) disable iff (!rst)
                                      (state_q == STEP) |-> (rem_q != '0));

endmodule

// File: tb/tb_mod12_count_ctrl.sv
// Integration bench: controller driving a behavioural mod-12 counter, checked by a per-cycle scoreboard.
module tb_mod12_count_ctrl;

   localparam logic [1:0] C_LOAD = 2'b00;
   localparam logic [1:0] C_UP   = 2'b01;
   localparam logic [1:0] C_DOWN = 2'b10;
   localparam logic [1:0] C_SEEK = 2'b11;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_arg;
   logic [3:0] count;
   logic       load;
   logic       mode;
   logic [3:0] data_in;
   logic       busy;
   logic       done;
   logic       err;

   typedef struct {
      logic [3:0] cnt;
      logic       ld;
      logic       md;
      logic [3:0] din;
      logic       dn;
      logic       er;
      logic       rdy;
   } exp_t;

   exp_t sb[$];
   int   m_count;
   int   errors;
   int   checks;

   mod12_count_ctrl #(
      .MODULUS (12),
      .CW      (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .count     (count),
      .load      (load),
      .mode      (mode),
      .data_in   (data_in),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // Behavioural mod-12 up/down counter with load and no enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= 4'd0;
      end else if (load) begin
         count <= data_in;
      end else if (mode) begin
         count <= (count == 4'd11) ? 4'd0 : count + 4'd1;
      end else begin
         count <= (count == 4'd0) ? 4'd11 : count - 4'd1;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input int c, input bit ld, input bit md, input int din,
                               input bit dn, input bit er, input bit rdy);
      exp_t e;
      e.cnt = 4'(c);
      e.ld  = ld;
      e.md  = md;
      e.din = 4'(din);
      e.dn  = dn;
      e.er  = er;
      e.rdy = rdy;
      return e;
   endfunction

   // Present a command in the current (idle) cycle, push the expected per-cycle trace,
   // and after the accept edge drive the given follow-on command inputs.
   task automatic push_cmd(input logic [1:0] op, input logic [3:0] arg,
                           input bit nv, input logic [1:0] nop, input logic [3:0] narg);
      int c0, n, d, fin;
      bit up, bad;
      c0  = m_count;
      n   = 0;
      up  = 1'b0;
      bad = 1'b0;
      case (op)
         C_LOAD: bad = (arg > 4'd11);
         C_UP: begin
            up = 1'b1;
            n  = int'(arg);
         end
         C_DOWN: n = int'(arg);
         default: begin
            bad = (arg > 4'd11) || (c0 > 11);
            if (!bad) begin
               d = (int'(arg) - c0 + 12) % 12;
               if (d <= 6) begin
                  up = 1'b1;
                  n  = d;
               end else begin
                  n = 12 - d;
               end
            end
         end
      endcase
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      if (op == C_LOAD && !bad) begin
         fin = int'(arg);
         sb.push_back(mk(c0, 1'b1, 1'b0, fin, 1'b0, 1'b0, 1'b0));
      end else begin
         fin = up ? (c0 + n) % 12 : (c0 - n + 120) % 12;
         for (int k = 1; k <= n; k++) begin
            sb.push_back(mk(up ? (c0 + k - 1) % 12 : (c0 - (k - 1) + 120) % 12,
                            1'b0, up, 0, 1'b0, 1'b0, 1'b0));
         end
      end
      sb.push_back(mk(fin, 1'b1, 1'b0, fin, 1'b1, bad, 1'b0));
      sb.push_back(mk(fin, 1'b1, 1'b0, fin, 1'b0, 1'b0, 1'b1));
      m_count = fin;
      @(posedge clk);
      #1;
      cmd_valid = nv;
      cmd_op    = nop;
      cmd_arg   = narg;
   endtask

   // Pop and compare n scoreboard entries, one per cycle, starting with the current cycle.
   task automatic drain(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: DUT cycle with no expected entry at %0t", $time);
            return;
         end
         e = sb.pop_front();
         checks++;
         if (count !== e.cnt) begin
            errors++;
            $display("FAIL count at %0t: got %0d want %0d", $time, count, e.cnt);
         end
         checks++;
         if (load !== e.ld) begin
            errors++;
            $display("FAIL load at %0t: got %b want %b", $time, load, e.ld);
         end
         checks++;
         if (mode !== e.md) begin
            errors++;
            $display("FAIL mode at %0t: got %b want %b", $time, mode, e.md);
         end
         if (e.ld) begin
            checks++;
            if (data_in !== e.din) begin
               errors++;
               $display("FAIL data_in at %0t: got %0d want %0d", $time, data_in, e.din);
            end
         end
         checks++;
         if (done !== e.dn) begin
            errors++;
            $display("FAIL done at %0t: got %b want %b", $time, done, e.dn);
         end
         checks++;
         if (err !== e.er) begin
            errors++;
            $display("FAIL err at %0t: got %b want %b", $time, err, e.er);
         end
         checks++;
         if (cmd_ready !== e.rdy || busy !== !e.rdy) begin
            errors++;
            $display("FAIL ready_busy at %0t: got ready=%b busy=%b want ready=%b", $time,
                     cmd_ready, busy, e.rdy);
         end
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg);
      push_cmd(op, arg, 1'b0, 2'b00, 4'd0);
      drain(sb.size());
   endtask

   task automatic test_reset;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_arg   = 4'd0;
      m_count   = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || load !== 1'b1 || mode !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b busy=%b load=%b mode=%b want 1 0 1 0",
                  cmd_ready, busy, load, mode);
      end
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || data_in !== count) begin
         errors++;
         $display("FAIL reset_resp: done=%b err=%b data_in=%0d count=%0d want 0 0 equal",
                  done, err, data_in, count);
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (count !== 4'd0 || load !== 1'b1 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: count=%0d load=%b ready=%b done=%b want 0 1 1 0",
                     count, load, cmd_ready, done);
         end
      end
   endtask

   task automatic test_load;
      run_cmd(C_LOAD, 4'd9);
      checks++;
      if (count !== 4'd9) begin
         errors++;
         $display("FAIL load9_final: got %0d want 9", count);
      end
      run_cmd(C_LOAD, 4'd13);
      checks++;
      if (count !== 4'd9) begin
         errors++;
         $display("FAIL load13_unchanged: got %0d want 9", count);
      end
   endtask

   task automatic test_step;
      run_cmd(C_LOAD, 4'd10);
      run_cmd(C_UP, 4'd3);
      @(posedge clk);
      #1;
      checks++;
      if (count !== 4'd1) begin
         errors++;
         $display("FAIL up3_hold: got %0d want 1", count);
      end
      run_cmd(C_DOWN, 4'd2);
      checks++;
      if (count !== 4'd11) begin
         errors++;
         $display("FAIL down2_final: got %0d want 11", count);
      end
   endtask

   task automatic test_seek;
      run_cmd(C_LOAD, 4'd2);
      run_cmd(C_SEEK, 4'd8);
      checks++;
      if (count !== 4'd8) begin
         errors++;
         $display("FAIL seek8_final: got %0d want 8", count);
      end
      run_cmd(C_LOAD, 4'd2);
      run_cmd(C_SEEK, 4'd10);
      checks++;
      if (count !== 4'd10) begin
         errors++;
         $display("FAIL seek10_final: got %0d want 10", count);
      end
      run_cmd(C_LOAD, 4'd2);
      run_cmd(C_SEEK, 4'd2);
      run_cmd(C_SEEK, 4'd12);
      checks++;
      if (count !== 4'd2) begin
         errors++;
         $display("FAIL seek12_unchanged: got %0d want 2", count);
      end
   endtask

   task automatic test_long_and_zero;
      run_cmd(C_LOAD, 4'd0);
      run_cmd(C_UP, 4'd15);
      checks++;
      if (count !== 4'd3) begin
         errors++;
         $display("FAIL up15_final: got %0d want 3", count);
      end
      run_cmd(C_UP, 4'd0);
      run_cmd(C_DOWN, 4'd0);
      checks++;
      if (count !== 4'd3) begin
         errors++;
         $display("FAIL zero_step_unchanged: got %0d want 3", count);
      end
   endtask

   task automatic test_back_to_back;
      // cmd_valid stays high with a LOAD while busy; it must wait for the idle cycle.
      push_cmd(C_UP, 4'd2, 1'b1, C_LOAD, 4'd7);
      drain(sb.size());
      run_cmd(C_LOAD, 4'd7);
      checks++;
      if (count !== 4'd7) begin
         errors++;
         $display("FAIL b2b_final: got %0d want 7", count);
      end
   endtask

   task automatic test_reset_abort;
      push_cmd(C_UP, 4'd10, 1'b0, 2'b00, 4'd0);
      drain(4);
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || load !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle: busy=%b ready=%b done=%b load=%b want 0 1 0 1",
                  busy, cmd_ready, done, load);
      end
      sb.delete();
      m_count = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b busy=%b count=%0d want 0 0 0",
                     done, busy, count);
         end
      end
      run_cmd(C_LOAD, 4'd5);
      checks++;
      if (count !== 4'd5) begin
         errors++;
         $display("FAIL abort_load5: got %0d want 5", count);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_load();
      test_step();
      test_seek();
      test_long_and_zero();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mod12_count_ctrl.md
# mod12_count_ctrl

Command-driven controller that sits in front of the mod-12 up/down counter and drives its `load`, `mode` and `data_in` inputs while watching its `count` output. It accepts one command at a time over a valid/ready handshake: load, step up N, step down N, or seek a target by the shortest path. It holds the counter still between commands and reports completion or error with a one-cycle pulse.

## Interface
- `MODULUS`, 12: counter modulus; legal count values are 0..MODULUS-1.
- `CW`, 4: counter/value width.
- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command (high only in IDLE).
- `cmd_op`  in  2  00 LOAD, 01 UP, 10 DOWN, 11 SEEK.
- `cmd_arg`  in  CW  LOAD/SEEK: target value; UP/DOWN: step count N (0..15).
- `count`  in  CW  counter output (feedback).
- `load`  out  1  to counter load.
- `mode`  out  1  to counter mode (1 = up).
- `data_in`  out  CW  to counter data_in.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse, coincident with `done`.

## Operation
- The counter has no enable and changes every clock unless loaded. Hold is therefore `load=1`, `data_in=count`. Hold is driven in IDLE and RESP, and during reset.
- States:
  - IDLE: hold, `cmd_ready=1`.
  - LOAD: `load=1`, `data_in=arg_q`.
  - STEP: `load=0`, `mode=dir_q`, `rem` decrements each cycle.
  - RESP: hold, `done=1`, `err=err_q`; next state is always IDLE.
- Accept on `cmd_valid && cmd_ready`. Latch `arg_q`, `dir_q`, `rem`, `err_q`. Next state depends on the op:
  - LOAD, `arg <= 11`: go to LOAD, then RESP.
  - UP/DOWN, N>0: go to STEP with `rem=N`, `dir_q` = 1 for UP, 0 for DOWN.
  - UP/DOWN, N=0: go directly to RESP.
  - SEEK: compute `d_up = (arg - count) mod 12`. If `d_up <= 6`, set `dir_q=1` and `rem=d_up`. Otherwise set `dir_q=0` and `rem=12-d_up`. A tie at 6 goes up. If `rem=0`, go directly to RESP; otherwise go to STEP.
  - Error: LOAD or SEEK with `arg > 11`, or SEEK with `count > 11` at accept. Go directly to RESP with `err_q=1`. The counter is not disturbed.
- STEP: when `rem==1`, the next state is RESP. Counter wrap (11→0 up, 0→11 down) is handled by the counter itself; the controller only counts steps.
- `done` and `err` come straight from the RESP state decode. `cmd_valid` is ignored while busy.

## Timing
- Reset (async assert): state=IDLE, `rem`/`arg_q`/`dir_q`/`err_q`=0. Outputs: `cmd_ready=1`, `load=1`, `mode=0`, `data_in=count`, `busy=0`, `done=0`, `err=0`. Deassertion is synchronous to `clk`.
- Reset mid-command aborts immediately to IDLE. No `done` is issued for the aborted command.
- Accept edge = E0.
  - LOAD: LOAD state in cycle 1; count=arg after E1; `done` in cycle 2; ready again in cycle 3.
  - STEP N: N cycles in STEP; count final after EN; `done` in cycle N+1; ready in cycle N+2.
  - Zero-step or error: `done` in cycle 1; ready in cycle 2.
- Command throughput: one command per (latency + 2) cycles; no back-to-back accept.
- The `data_in=count` hold path is combinational. No other combinational input→output paths exist except `cmd_ready` from state.

## Structure
- Package `mod12_pkg`:
  - `MODULUS` and `CW` defaults.
  - op encodings `OP_LOAD`, `OP_UP`, `OP_DOWN`, `OP_SEEK`.
  - state enum `ctrl_state_t` {IDLE, LOAD, STEP, RESP}.
- Sub-module `mod12_dist`: combinational; inputs `cur`, `tgt`; outputs `dir`, `steps` (0..6) and `bad` (either input > 11). It is instantiated once for SEEK.
- Top level: FSM, argument/step registers, output decode.
- Integration bench instantiates `mod12_count_ctrl` with the counter.

## Test plan
- Reset, then idle for 5 cycles with the counter at 0 → count stays 0, `load=1`, `cmd_ready=1`, no `done`.
- LOAD 9 → count=9 after E1, `done` in cycle 2, `err=0`. LOAD 13 → `done`+`err` in cycle 1, count unchanged.
- From count=10: UP 3 → 11, 0, 1; `done` in cycle 4, count holds at 1. From count=1: DOWN 2 → 0, 11.
- SEEK from 2: target 8 → up 6 steps (tie); target 10 → down 4 steps; target 2 → `done` cycle 1, no step; target 12 → `err`.
- UP 15 from 0 → final count 3, `done` in cycle 16. UP 0 → immediate `done`, count unchanged.
- Assert `rst` low in the middle of UP 10 → state IDLE at once, no `done`. After release, LOAD 5 completes normally.
